event_flasher: RTL and testbench

- Output-side counterpart to the key-press pulse conditioner: it turns single-cycle event pulses into visible, fixed-length flashes on an LED or buzzer line.
- Each accepted event produces exactly one Out high window of ON_CYCLES cycles, followed by a mandatory low gap of GAP_CYCLES cycles.
- Events arriving while a flash or gap is in progress are queued in a saturating counter and replayed in order, so fast game events never merge or vanish silently.
- Sits between game logic (move/collision/score pulses) and board LEDR/GPIO outputs.

---
 rtl/event_flasher.sv | 106 ++++++++++
 tb/tb_event_flasher.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/event_flasher.sv
// event_flasher: turns single-cycle event pulses into fixed-length flashes.
// Each accepted event gives one ON_CYCLES-long high window on out, followed by
// a GAP_CYCLES-long low gap. Events arriving mid-flash or mid-gap are counted
// in a saturating pending counter and replayed in order.
//
// Ports:
//   clock    - system clock, rising edge
//   reset_n  - asynchronous active-low reset
//   pulse    - event strobe, one event per cycle sampled high
//   clear    - synchronous clear of pending and overflow
//   out      - registered flash output
//   busy     - high whenever the FSM is not idle
//   pending  - queued events not yet flashed
//   overflow - sticky, set when an event is dropped at saturation
module event_flasher #(
  parameter int ON_CYCLES   = 8,
  parameter int GAP_CYCLES  = 4,
  parameter int MAX_PENDING = 3,
  localparam int PW = $clog2(MAX_PENDING + 1)
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          pulse,
  input  logic          clear,
  output logic          out,
  output logic          busy,
  output logic [PW-1:0] pending,
  output logic          overflow
);

  localparam int TMAX = (ON_CYCLES > GAP_CYCLES) ? ON_CYCLES : GAP_CYCLES;
  localparam int TW   = $clog2(TMAX + 1);
  localparam logic [TW-1:0] ON_LOAD  = TW'(ON_CYCLES - 1);
  localparam logic [TW-1:0] GAP_LOAD = TW'(GAP_CYCLES - 1);
  localparam logic [PW-1:0] PEND_MAX = PW'(MAX_PENDING);

  typedef enum logic [1:0] {IDLE, ON, GAP} state_t;

  state_t        state;
  logic [TW-1:0] timer;
  logic          gap_end, have_pending, inc, dec;

  assign gap_end      = (state == GAP) && (timer == '0);
  assign have_pending = (pending != '0);
  // A pulse is queued unless it starts a flash by itself: from IDLE, or at the
  // end of a gap with nothing queued ahead of it. With something queued at gap
  // end, the pulse goes in behind the consumed event (inc and dec cancel).
  assign inc = pulse && (state != IDLE) && !(gap_end && !have_pending);
  assign dec = gap_end && have_pending;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      timer    <= '0;
      out      <= 1'b0;
      busy     <= 1'b0;
      pending  <= '0;
      overflow <= 1'b0;
    end else begin
      // out/busy are loaded from the next state so they stay plain flops.
      case (state)
        IDLE: if (pulse) begin
          state <= ON;
          timer <= ON_LOAD;
          out   <= 1'b1;
          busy  <= 1'b1;
        end
        ON: if (timer != '0) begin
          timer <= timer - 1'b1;
        end else begin
          state <= GAP;
          timer <= GAP_LOAD;
          out   <= 1'b0;
        end
        GAP: if (!gap_end) begin
          timer <= timer - 1'b1;
        end else if (have_pending || pulse) begin
          state <= ON;
          timer <= ON_LOAD;
          out   <= 1'b1;
        end else begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          timer <= '0;
          out   <= 1'b0;
          busy  <= 1'b0;
        end
      endcase

      // clear beats a same-cycle inc: that event is dropped silently.
      if (clear) begin
        pending  <= '0;
        overflow <= 1'b0;
      end else if (inc && !dec) begin
        if (pending == PEND_MAX) overflow <= 1'b1;
        else                     pending  <= pending + 1'b1;
      end else if (dec && !inc) begin
        pending <= pending - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_event_flasher.sv
// Scoreboard bench for event_flasher (ON=8, GAP=4, MAX_PENDING=3).
// Stimulus pushes cycle-stamped expectations; a monitor on the falling edge
// pops every entry due at the current cycle and compares the masked fields.
module tb_event_flasher;

  logic       clock = 1'b0;
  logic       reset_n, pulse, clear;
  logic       out, busy, overflow;
  logic [1:0] pending;

  event_flasher #(.ON_CYCLES(8), .GAP_CYCLES(4), .MAX_PENDING(3)) dut (
    .clock(clock), .reset_n(reset_n), .pulse(pulse), .clear(clear),
    .out(out), .busy(busy), .pending(pending), .overflow(overflow)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // mask bits: [3] out, [2] busy, [1] pending, [0] overflow
  typedef struct {
    int         c;
    logic [3:0] m;
    logic       o, b, v;
    logic [1:0] p;
    string      nm;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;

  task automatic push(int c, logic [3:0] m, logic o, logic b, logic [1:0] p, logic v, string nm);
    exp_t e;
    e.c = c; e.m = m; e.o = o; e.b = b; e.p = p; e.v = v; e.nm = nm;
    sb.push_back(e);
  endtask

  // Hand-derived timeline: flash i starts at r = 1 + 12*i (8 high, 4 low),
  // busy covers all n flashes and gaps, then tail cycles of idle.
  task automatic push_flashes(int base, int n, int tail, string nm);
    for (int r = 1; r <= 12 * n + tail; r++) begin
      logic inwin, hi;
      inwin = (r <= 12 * n);
      hi    = inwin && (((r - 1) % 12) < 8);
      push(base + r, 4'b1100, hi, inwin, 2'd0, 1'b0, nm);
    end
  endtask

  always @(negedge clock) begin
    int i;
    i = 0;
    while (i < sb.size()) begin
      if (sb[i].c == cyc) begin
        checks++;
        if ((sb[i].m[3] && out !== sb[i].o) || (sb[i].m[2] && busy !== sb[i].b) ||
            (sb[i].m[1] && pending !== sb[i].p) || (sb[i].m[0] && overflow !== sb[i].v)) begin
          failures++;
          $display("FAIL %s cyc=%0d got out=%b busy=%b pend=%0d ovf=%b want out=%b busy=%b pend=%0d ovf=%b mask=%b",
                   sb[i].nm, cyc, out, busy, pending, overflow,
                   sb[i].o, sb[i].b, sb[i].p, sb[i].v, sb[i].m);
        end
        sb.delete(i);
      end else if (sb[i].c < cyc) begin
        checks++;
        failures++;
        $display("FAIL %s missed expectation at cyc=%0d (now %0d)", sb[i].nm, sb[i].c, cyc);
        sb.delete(i);
      end else begin
        i++;
      end
    end
  end

  task automatic go_to(int c);
    while (cyc < c) @(negedge clock);
  endtask

  task automatic pulse_rel(int base, int r);
    go_to(base + r);
    pulse = 1'b1;
    @(negedge clock);
    pulse = 1'b0;
  endtask

  initial begin
    int p;
    reset_n = 1'b0; pulse = 1'b0; clear = 1'b0;

    // 1: reset and idle
    for (int c = 1; c <= 22; c++) push(c, 4'b1111, 1'b0, 1'b0, 2'd0, 1'b0, "reset_idle");
    go_to(2);
    reset_n = 1'b1;
    go_to(23);

    // 2: single flash
    p = 25;
    push_flashes(p, 1, 2, "single");
    push(p + 1, 4'b0011, 1'b0, 1'b0, 2'd0, 1'b0, "single_pend");
    push(p + 13, 4'b1111, 1'b0, 1'b0, 2'd0, 1'b0, "single_idle");
    pulse_rel(p, 0);
    go_to(p + 15);

    // 3: three events, queue 2 deep
    p = 45;
    push_flashes(p, 3, 2, "three");
    push(p + 2,  4'b0010, 1'b0, 1'b0, 2'd0, 1'b0, "three_p0");
    push(p + 3,  4'b0010, 1'b0, 1'b0, 2'd1, 1'b0, "three_p1");
    push(p + 5,  4'b0010, 1'b0, 1'b0, 2'd2, 1'b0, "three_p2");
    push(p + 12, 4'b0010, 1'b0, 1'b0, 2'd2, 1'b0, "three_gapend");
    push(p + 13, 4'b0010, 1'b0, 1'b0, 2'd1, 1'b0, "three_dec1");
    push(p + 24, 4'b0010, 1'b0, 1'b0, 2'd1, 1'b0, "three_hold1");
    push(p + 25, 4'b0010, 1'b0, 1'b0, 2'd0, 1'b0, "three_dec0");
    push(p + 37, 4'b1111, 1'b0, 1'b0, 2'd0, 1'b0, "three_idle");
    pulse_rel(p, 0); pulse_rel(p, 2); pulse_rel(p, 4);
    go_to(p + 40);

    // 4: saturation and sticky overflow, then clear from idle
    p = 90;
    push_flashes(p, 4, 2, "sat");
    push(p + 2,  4'b0011, 1'b0, 1'b0, 2'd1, 1'b0, "sat_p1");
    push(p + 3,  4'b0011, 1'b0, 1'b0, 2'd2, 1'b0, "sat_p2");
    push(p + 4,  4'b0011, 1'b0, 1'b0, 2'd3, 1'b0, "sat_p3");
    push(p + 5,  4'b0011, 1'b0, 1'b0, 2'd3, 1'b1, "sat_ovf");
    push(p + 6,  4'b0011, 1'b0, 1'b0, 2'd3, 1'b1, "sat_hold");
    push(p + 13, 4'b0011, 1'b0, 1'b0, 2'd2, 1'b1, "sat_d2");
    push(p + 25, 4'b0011, 1'b0, 1'b0, 2'd1, 1'b1, "sat_d1");
    push(p + 37, 4'b0011, 1'b0, 1'b0, 2'd0, 1'b1, "sat_d0");
    push(p + 49, 4'b1111, 1'b0, 1'b0, 2'd0, 1'b1, "sat_sticky");
    push(p + 52, 4'b0011, 1'b0, 1'b0, 2'd0, 1'b1, "sat_preclr");
    push(p + 53, 4'b1111, 1'b0, 1'b0, 2'd0, 1'b0, "sat_clr");
    for (int r = 0; r <= 5; r++) pulse_rel(p, r);
    go_to(p + 52);
    clear = 1'b1;
    @(negedge clock);
    clear = 1'b0;
    go_to(p + 55);

    // 5: pulse on the last gap cycle with one queued
    p = 150;
    push_flashes(p, 3, 2, "lastgap");
    push(p + 3,  4'b0010, 1'b0, 1'b0, 2'd1, 1'b0, "lastgap_q1");
    push(p + 12, 4'b0010, 1'b0, 1'b0, 2'd1, 1'b0, "lastgap_pre");
    push(p + 13, 4'b0011, 1'b0, 1'b0, 2'd1, 1'b0, "lastgap_keep");
    push(p + 24, 4'b0010, 1'b0, 1'b0, 2'd1, 1'b0, "lastgap_hold");
    push(p + 25, 4'b0010, 1'b0, 1'b0, 2'd0, 1'b0, "lastgap_d0");
    push(p + 37, 4'b1111, 1'b0, 1'b0, 2'd0, 1'b0, "lastgap_idle");
    pulse_rel(p, 0); pulse_rel(p, 2); pulse_rel(p, 12);
    go_to(p + 40);

    // 6a: async reset mid-flash with two queued, then a clean flash
    p = 195;
    push(p + 5, 4'b0010, 1'b0, 1'b0, 2'd2, 1'b0, "rst_pre_q");
    push(p + 6, 4'b1111, 1'b1, 1'b1, 2'd2, 1'b0, "rst_pre");
    pulse_rel(p, 0); pulse_rel(p, 2); pulse_rel(p, 4);
    go_to(p + 6);
    @(posedge clock);
    #1 reset_n = 1'b0;
    // the next falling edge comes before any rising edge: async effect only
    for (int r = 7; r <= 12; r++) push(p + r, 4'b1111, 1'b0, 1'b0, 2'd0, 1'b0, "rst_async");
    go_to(p + 8);
    reset_n = 1'b1;
    push_flashes(p + 12, 1, 2, "rst_after");
    push(p + 13, 4'b0011, 1'b0, 1'b0, 2'd0, 1'b0, "rst_after_pend");
    pulse_rel(p + 12, 0);
    go_to(p + 28);

    // 6b: clear (with a colliding pulse) during the gap
    p = 240;
    push_flashes(p, 1, 3, "clrgap");
    push(p + 5,  4'b0011, 1'b0, 1'b0, 2'd3, 1'b1, "clrgap_sat");
    push(p + 10, 4'b1111, 1'b0, 1'b1, 2'd3, 1'b1, "clrgap_pre");
    push(p + 11, 4'b1111, 1'b0, 1'b1, 2'd0, 1'b0, "clrgap_clr");
    push(p + 12, 4'b1111, 1'b0, 1'b1, 2'd0, 1'b0, "clrgap_end");
    push(p + 13, 4'b1111, 1'b0, 1'b0, 2'd0, 1'b0, "clrgap_idle");
    for (int r = 0; r <= 4; r++) pulse_rel(p, r);
    go_to(p + 10);
    pulse = 1'b1; clear = 1'b1;
    @(negedge clock);
    pulse = 1'b0; clear = 1'b0;
    go_to(p + 16);

    // drain, bounded
    for (int k = 0; k < 200 && sb.size() != 0; k++) @(negedge clock);
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL drain %0d expectations left unchecked, want 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
